// File: rtl/multiword_adder.sv
// Multi-word adder/subtractor: W = 16*WORDS operands summed one 16-bit chunk
// per cycle through a single ripple-carry slice, LSB chunk first.
// Optional build macro: MULTIWORD_ADDER_SAT_EN saturates result on signed overflow.

// 16-bit ripple-carry slice with carry-out and signed-overflow detection
module rca_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        overflow_detection
);

  logic [16:0] c;

  // Bitwise full-adder chain
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 16; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout               = c[16];
  assign overflow_detection = c[16] ^ c[15];

endmodule

module multiword_adder #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sub,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   result,
  output logic                  cout,
  output logic                  overflow,
  output logic                  zero
);

  localparam int unsigned W     = 16 * WORDS;
  localparam int unsigned IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [W-1:0]     a_q, a_n;
  logic [W-1:0]     b_q, b_n;
  logic             carry_q, carry_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [W-1:0]     result_n;
  logic             cout_n, overflow_n;
  logic             busy_n, done_n;

  logic [15:0]      a_chunk, b_chunk, sum_chunk;
  logic             rca_cout, rca_ovf;

  // Select the active chunk of both latched operands
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*16 +: 16];
        b_chunk = b_q[i*16 +: 16];
      end
    end
  end

  rca_16 u_rca (
    .a                  (a_chunk),
    .b                  (b_chunk),
    .cin                (carry_q),
    .sum                (sum_chunk),
    .cout               (rca_cout),
    .overflow_detection (rca_ovf)
  );

  // Next-state and datapath update
  always_comb begin
    state_n    = state_q;
    a_n        = a_q;
    b_n        = b_q;
    carry_n    = carry_q;
    idx_n      = idx_q;
    result_n   = result;
    cout_n     = cout;
    overflow_n = overflow;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n    = RUN;
          a_n        = a;
          b_n        = sub ? ~b : b;
          carry_n    = sub;
          idx_n      = '0;
          result_n   = '0;
          cout_n     = 1'b0;
          overflow_n = 1'b0;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < WORDS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            result_n[i*16 +: 16] = sum_chunk;
          end
        end
        carry_n = rca_cout;
        idx_n   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(WORDS - 1)) begin
          state_n    = DONE;
          idx_n      = '0;
          cout_n     = rca_cout;
          overflow_n = rca_ovf;
`ifdef MULTIWORD_ADDER_SAT_EN
          // Clamp toward the sign of a; flags keep the raw outcome
          if (rca_ovf) begin
            result_n = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end
`endif
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      a_q      <= a_n;
      b_q      <= b_n;
      carry_q  <= carry_n;
      idx_q    <= idx_n;
      result   <= result_n;
      cout     <= cout_n;
      overflow <= overflow_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_multiword_adder.sv
// Directed bench for multiword_adder (WORDS=4) with a whole-word reference model.
module tb_multiword_adder;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  multiword_adder #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-word reference: returns {overflow, cout, result}
  function automatic logic [W+1:0] model_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         ov;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
    r    = full[W-1:0];
    ov   = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
`ifdef MULTIWORD_ADDER_SAT_EN
    if (ov) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {ov, full[W], r};
  endfunction

  // Cycle-level expectation: countdown of remaining chunk cycles, then one done cycle
  int           m_left  = 0;
  logic         m_done  = 1'b0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_res   = '0;
  logic         m_cout  = 1'b0;
  logic         m_ovf   = 1'b0;
  logic [W+1:0] m_pend  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_valid <= 1'b1;
      m_res   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done  <= 1'b1;
        m_valid <= 1'b1;
        m_ovf   <= m_pend[W+1];
        m_cout  <= m_pend[W];
        m_res   <= m_pend[W-1:0];
      end
    end else if (start) begin
      m_left  <= WORDS;
      m_valid <= 1'b0;
      m_pend  <= model_op(a, b, sub);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", W'(busy), W'(m_left > 0));
      chk("done", W'(done), W'(m_done));
      if (m_valid) begin
        chk("result", result, m_res);
        chk("cout", W'(cout), W'(m_cout));
        chk("overflow", W'(overflow), W'(m_ovf));
        chk("zero", W'(zero), W'(m_res == '0));
      end
    end
  end

  // One operation with hand-computed expectations and latency/busy-width checks
  task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic s, input logic [W-1:0] e_res, input logic e_cout,
                        input logic e_ovf, input logic e_zero);
    int n;
    int nbusy;
    @(posedge clk); #1;
    start = 1'b1; a = xa; b = xb; sub = s;
    @(posedge clk); #1;
    start = 1'b0;
    // operands must be ignored after acceptance
    a = ~xa; b = ~xb; sub = ~s;
    n = 0;
    nbusy = 0;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, W'(n), W'(WORDS));
    chk({name, "_busy_cycles"}, W'(nbusy), W'(WORDS));
    chk({name, "_result"}, result, e_res);
    chk({name, "_cout"}, W'(cout), W'(e_cout));
    chk({name, "_overflow"}, W'(overflow), W'(e_ovf));
    chk({name, "_zero"}, W'(zero), W'(e_zero));
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, W'(done), W'(0));
    chk({name, "_hold"}, result, e_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int dn;
    logic [W-1:0] got;

    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_result", result, '0);
    chk("rst_zero", W'(zero), W'(1));
    chk("rst_cout", W'(cout), W'(0));
    chk("rst_ovf", W'(overflow), W'(0));
    reset = 1'b0;
    chk_en = 1'b1;

    run_op("carry16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    run_op("wrap_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
           64'h0, 1'b1, 1'b0, 1'b1);
`ifdef MULTIWORD_ADDER_SAT_EN
    run_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
           64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
`else
    run_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
    run_op("sub_borrow", 64'h5, 64'h7, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_pos", 64'h7, 64'h5, 1'b1,
           64'h2, 1'b1, 1'b0, 1'b0);
    run_op("sub_eq", 64'h1234_0000_ABCD_0001, 64'h1234_0000_ABCD_0001, 1'b1,
           64'h0, 1'b1, 1'b0, 1'b1);

    // Second start during RUN is ignored
    @(posedge clk); #1;
    start = 1'b1; sub = 1'b0;
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; sub = 1'b1; a = 64'h9; b = 64'h3;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dn++;
        got = result;
      end
    end
    chk("restart_done_count", W'(dn), W'(1));
    chk("restart_result", got, 64'h2345_6789_ABCD_F001);

    // Reset on the second RUN cycle aborts the operation
    @(posedge clk); #1;
    start = 1'b1; sub = 1'b0; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_result", result, '0);
    chk("abort_zero", W'(zero), W'(1));
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort_no_done", W'(dn), W'(0));
    run_op("after_abort", 64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiword_adder.md
MULTIWORD_ADDER -- requirements
Module: multiword_adder

Interface
REQ-001 SHALL have parameter WORDS, default 4, meaning the number of 16-bit chunks per operand; legal range is 2..8, and the operand width is W = 16*WORDS.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port sub, input, 1 bit: 0 selects a+b; 1 selects a-b, computed as a + ~b + 1.
REQ-006 SHALL have ports a and b, input, W bits each: operands, captured when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 SHALL have port done, output, 1 bit: high exactly while in DONE, a one-cycle pulse.
REQ-009 SHALL have port result, output, W bits: sum or difference.
REQ-010 SHALL have port cout, output, 1 bit: carry out of the MSB; for sub, 1 means no borrow.
REQ-011 SHALL have port overflow, output, 1 bit: signed overflow, equal to carry into bit W-1 XOR carry out of bit W-1.
REQ-012 SHALL have port zero, output, 1 bit: high when result equals 0.

Function
REQ-013 SHALL implement a three-state FSM: IDLE -> RUN on start; RUN -> DONE after WORDS chunk cycles; DONE -> IDLE unconditionally.
REQ-014 SHALL, on accepting start in IDLE:
- latch a;
- latch b, or ~b when sub=1;
- set the carry register to sub;
- set the chunk index to 0;
- clear result, cout and overflow.
REQ-015 SHALL, in each RUN cycle:
- add chunk[index] of both latched operands plus the carry register using one instance of the 16-bit ripple-carry adder RCA_16;
- write the sum to result[16*index+15 : 16*index];
- load the carry register from the adder's cout;
- increment the index.
REQ-016 SHALL, on the final chunk (index = WORDS-1), load cout and overflow from the adder's cout and overflow_detection outputs, and enter DONE.
REQ-017 SHALL make latency fixed: done is high in the cycle that follows exactly WORDS rising edges after the edge that accepted start.
REQ-018 SHALL ignore start while in RUN or DONE; there is no queuing.
REQ-019 SHALL ignore changes on a, b and sub after acceptance.
REQ-020 SHALL hold result, cout, overflow and zero stable from DONE until the next accepted start.
REQ-021 SHALL let chunk arithmetic wrap modulo 2^16, with inter-chunk carry carried only through the carry register; there is no combinational path from a or b to result.
REQ-022 SHALL derive zero combinationally from the result register.

Reset
REQ-023 SHALL, when reset=1 at a rising edge:
- force IDLE, index 0 and carry 0;
- clear result, cout and overflow;
- drive busy=0, done=0 and zero=1.
REQ-024 SHALL give reset priority over start and over any in-progress RUN or DONE; a partial result is discarded and no done pulse occurs.

Configuration
REQ-025 SHALL, when macro MULTIWORD_ADDER_SAT_EN is defined, replace result on entry to DONE whenever overflow=1:
- with 0x7FFF..F (W bits) when the latched a MSB is 0;
- with 0x8000..0 when the latched a MSB is 1;
- cout and overflow still report the raw values.
REQ-026 SHALL, when MULTIWORD_ADDER_SAT_EN is undefined, leave result as the raw wrapped sum; no saturation logic is synthesized.

Verification (WORDS=4)
REQ-027 SHALL cover: a=0x0000_0000_0000_FFFF, b=1, sub=0 -> result=0x0000_0000_0001_0000, cout=0, overflow=0, zero=0, done high exactly 4 edges after the start edge, busy high for 4 cycles.
REQ-028 SHALL cover: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> result=0, cout=1, overflow=0, zero=1.
REQ-029 SHALL cover: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> overflow=1, cout=0; result=0x8000_0000_0000_0000 without the macro, 0x7FFF_FFFF_FFFF_FFFF with MULTIWORD_ADDER_SAT_EN.
REQ-030 SHALL cover: a=5, b=7, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0.
REQ-031 SHALL cover: start pulsed again during RUN with different operands -> ignored; the first operation's result appears and exactly one done pulse occurs.
REQ-032 SHALL cover: reset asserted on the 2nd RUN cycle -> next cycle in IDLE with busy=0, result=0, zero=1, no done pulse; a following start with a=1, b=2 -> result=3.
